store_buffer: RTL and testbench

Posted-write buffer between the MEM stage and main memory. Retiring stores (`MemWriteM`) are queued so the pipeline does not wait for a slow memory write. The buffer drains them in order over a req/ack interface. Loads in MEM are forwarded from the youngest matching pending store, and `full` feeds the hazard unit as a stall source.

---
 rtl/store_buffer_if.sv | 29 ++
 rtl/store_buffer.sv | 159 +++++++++++++++
 tb/tb_store_buffer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Bundles the store, load-forward and memory-write signals of the store buffer.
// master = pipeline/memory side, slave = the buffer itself.
interface store_buffer_if #(
  parameter int PTRW = 2
);
  logic          st_valid;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic          full;
  logic [31:0]   ld_addr;
  logic          ld_hit;
  logic [31:0]   ld_data;
  logic          mem_wr_req;
  logic [31:0]   mem_wr_addr;
  logic [31:0]   mem_wr_data;
  logic          mem_wr_ack;
  logic          empty;
  logic [PTRW:0] count;

  modport master (
    output st_valid, st_addr, st_data, ld_addr, mem_wr_ack,
    input  full, ld_hit, ld_data, mem_wr_req, mem_wr_addr, mem_wr_data, empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_addr, mem_wr_ack,
    output full, ld_hit, ld_data, mem_wr_req, mem_wr_addr, mem_wr_data, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order drain over req/ack, youngest-match load forwarding.
// Optional STORE_BUF_COALESCE_EN merges a store into the youngest matching non-issuing entry.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTRW  = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic reset,
  store_buffer_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;

  localparam logic [PTRW:0]   DEPTH_C = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0]   CNT_ONE = (PTRW+1)'(1);
  localparam logic [PTRW-1:0] PTR_ONE = PTRW'(1);

  state_e          state_q, state_d;
  logic            mem_wr_req_q;
  logic [PTRW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTRW:0]   count_q, count_d;
  logic [DEPTH-1:0] valid_q;
  logic [29:0]     addr_q [DEPTH];
  logic [31:0]     data_q [DEPTH];

  logic            full_s, enq_s, deq_s, coal_s;
  logic [PTRW-1:0] coal_idx_s, fwd_idx_s;
  logic            ld_hit_s;
  logic [31:0]     ld_data_s;
  logic [29:0]     st_word_s;
  logic            unused_s;

  assign st_word_s = bus.st_addr[31:2];
  assign unused_s  = ^{bus.st_addr[1:0], bus.ld_addr[1:0]};
  assign full_s    = (count_q == DEPTH_C);
  assign deq_s     = (state_q == REQ) && bus.mem_wr_ack;
  assign enq_s     = bus.st_valid && !full_s && !coal_s;

`ifdef STORE_BUF_COALESCE_EN
  logic [PTRW-1:0] coal_scan_s;
  // Youngest matching entry for an incoming store; the issuing head is off limits
  always_comb begin
    coal_s      = 1'b0;
    coal_idx_s  = {PTRW{1'b0}};
    coal_scan_s = {PTRW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      coal_scan_s = tail_q - PTRW'(i + 1);
      if (bus.st_valid && !coal_s && valid_q[coal_scan_s] &&
          (addr_q[coal_scan_s] == st_word_s) &&
          !((state_q == REQ) && (coal_scan_s == head_q))) begin
        coal_s     = 1'b1;
        coal_idx_s = coal_scan_s;
      end else begin
        coal_s     = coal_s;
      end
    end
  end
`else
  assign coal_s     = 1'b0;
  assign coal_idx_s = {PTRW{1'b0}};
`endif

  // Load forwarding: scan from the youngest entry backwards, first hit wins
  always_comb begin
    ld_hit_s  = 1'b0;
    ld_data_s = 32'h0000_0000;
    fwd_idx_s = {PTRW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx_s = tail_q - PTRW'(i + 1);
      if (!ld_hit_s && valid_q[fwd_idx_s] && (addr_q[fwd_idx_s] == bus.ld_addr[31:2])) begin
        ld_hit_s  = 1'b1;
        ld_data_s = data_q[fwd_idx_s];
      end else begin
        ld_hit_s  = ld_hit_s;
      end
    end
  end

  // Pointer, occupancy and drain FSM next-state
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq_s) begin
      tail_d = tail_q + PTR_ONE;
    end else begin
      tail_d = tail_q;
    end
    if (deq_s) begin
      head_d = head_q + PTR_ONE;
    end else begin
      head_d = head_q;
    end
    case ({enq_s, deq_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    case (state_q)
      IDLE: begin
        if ((count_q != {(PTRW+1){1'b0}}) || enq_s) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (deq_s) begin
          state_d = IDLE;
        end else begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers and entry storage
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      mem_wr_req_q <= 1'b0;
      head_q       <= {PTRW{1'b0}};
      tail_q       <= {PTRW{1'b0}};
      count_q      <= {(PTRW+1){1'b0}};
      valid_q      <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 30'h0;
        data_q[i] <= 32'h0000_0000;
      end
    end else begin
      state_q      <= state_d;
      mem_wr_req_q <= (state_d == REQ);
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      if (deq_s) begin
        valid_q[head_q] <= 1'b0;
      end
      if (enq_s) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= st_word_s;
        data_q[tail_q]  <= bus.st_data;
      end
      if (coal_s) begin
        data_q[coal_idx_s] <= bus.st_data;
      end
    end
  end

  assign bus.full        = full_s;
  assign bus.empty       = (count_q == {(PTRW+1){1'b0}});
  assign bus.count       = count_q;
  assign bus.ld_hit      = ld_hit_s;
  assign bus.ld_data     = ld_data_s;
  assign bus.mem_wr_req  = mem_wr_req_q;
  assign bus.mem_wr_addr = {addr_q[head_q], 2'b00};
  assign bus.mem_wr_data = data_q[head_q];
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int PTRW  = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_drop  = 0;
  bit   check_en = 1'b0;

  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  bit          m_req;
  logic [31:0] m_log_a[$], m_log_d[$];
  logic [31:0] dut_a[$], dut_d[$];

  store_buffer_if #(.PTRW(PTRW)) bus ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: one step of the spec rules using the inputs about to be sampled.
  task automatic model_step();
    int  sz;
    bit  enq, deq, coal;
    sz = mq.size(); enq = 1'b0; coal = 1'b0;
    if (!reset) begin
      mq.delete();
      m_req = 1'b0;
    end else begin
      deq = m_req && bus.mem_wr_ack;
      if (bus.st_valid) begin
`ifdef STORE_BUF_COALESCE_EN
        for (int i = sz - 1; i >= 0; i--) begin
          if (!coal && mq[i].a == bus.st_addr[31:2] && !(i == 0 && m_req)) begin
            mq[i].d = bus.st_data;
            coal = 1'b1;
          end
        end
`endif
        if (!coal) begin
          if (sz < DEPTH) enq = 1'b1;
          else n_drop++;
        end
      end
      if (deq) begin
        m_log_a.push_back({mq[0].a, 2'b00});
        m_log_d.push_back(mq[0].d);
        void'(mq.pop_front());
      end
      if (enq) mq.push_back('{a: bus.st_addr[31:2], d: bus.st_data});
      m_req = m_req ? !deq : (sz > 0 || enq);
    end
  endtask

  task automatic tick();
    if (reset && bus.mem_wr_req && bus.mem_wr_ack) begin
      dut_a.push_back(bus.mem_wr_addr);
      dut_d.push_back(bus.mem_wr_data);
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.st_valid = 1'b0; bus.mem_wr_ack = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    dut_a.delete(); dut_d.delete(); m_log_a.delete(); m_log_d.delete();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.st_valid = 1'b1; bus.st_addr = a; bus.st_data = d;
    tick();
    bus.st_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    int guard;
    guard = 0;
    while (dut_a.size() < n && guard < 200) begin
      bus.mem_wr_ack = bus.mem_wr_req;
      tick();
      guard++;
    end
    bus.mem_wr_ack = 1'b0;
    chk("drain_bound", 32'(guard < 200), 32'd1);
  endtask

  // Compare process: DUT against the reference model every cycle.
  always @(negedge clk) begin
    int          sz;
    logic        hit;
    logic [31:0] ld;
    if (check_en) begin
      sz  = mq.size();
      hit = 1'b0;
      ld  = 32'h0;
      for (int i = sz - 1; i >= 0; i--) begin
        if (!hit && mq[i].a == bus.ld_addr[31:2]) begin
          hit = 1'b1;
          ld  = mq[i].d;
        end
      end
      chk("count", 32'(bus.count), 32'(sz));
      chk("empty", 32'(bus.empty), 32'(sz == 0));
      chk("full", 32'(bus.full), 32'(sz == DEPTH));
      chk("mem_wr_req", 32'(bus.mem_wr_req), 32'(m_req));
      chk("ld_hit", 32'(bus.ld_hit), 32'(hit));
      chk("ld_data", bus.ld_data, ld);
      if (sz > 0) begin
        chk("mem_wr_addr", bus.mem_wr_addr, {mq[0].a, 2'b00});
        chk("mem_wr_data", bus.mem_wr_data, mq[0].d);
      end
    end
  end

  initial begin
    int target;
    reset = 1'b0;
    bus.st_valid = 1'b0; bus.st_addr = 32'h0; bus.st_data = 32'h0;
    bus.ld_addr = 32'h0; bus.mem_wr_ack = 1'b0;
    @(negedge clk); #1;
    do_reset();
    check_en = 1'b1;

    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_req", 32'(bus.mem_wr_req), 32'd0);
    chk("rst_ld_hit", 32'(bus.ld_hit), 32'd0);
    chk("rst_ld_data", bus.ld_data, 32'd0);

    // Single store, ack after three request cycles
    store(32'h10, 32'hAAAA);
    for (int i = 0; i < 3; i++) begin
      chk("t1_req", 32'(bus.mem_wr_req), 32'd1);
      chk("t1_addr", bus.mem_wr_addr, 32'h10);
      chk("t1_data", bus.mem_wr_data, 32'hAAAA);
      tick();
    end
    bus.mem_wr_ack = 1'b1; tick(); bus.mem_wr_ack = 1'b0;
    chk("t1_empty", 32'(bus.empty), 32'd1);
    chk("t1_req_low", 32'(bus.mem_wr_req), 32'd0);
    chk("t1_written", dut_d.size() > 0 ? dut_d[0] : 32'hDEAD, 32'hAAAA);

    // Fill, drop a fifth store, then drain in order
    do_reset();
    for (int i = 0; i < 4; i++) store(32'(4 * i), 32'h100 + 32'(i));
    chk("t2_full", 32'(bus.full), 32'd1);
    chk("t2_count", 32'(bus.count), 32'd4);
    store(32'h20, 32'h555);
    chk("t2_count_drop", 32'(bus.count), 32'd4);
    drain(4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_order_addr", dut_a.size() > i ? dut_a[i] : 32'hDEAD, 32'(4 * i));
      chk("t2_order_data", dut_d.size() > i ? dut_d[i] : 32'hDEAD, 32'h100 + 32'(i));
    end

    // Forwarding picks the youngest match
    do_reset();
    store(32'h40, 32'd1);
    store(32'h40, 32'd2);
    bus.ld_addr = 32'h40; #1;
    chk("t3_hit", 32'(bus.ld_hit), 32'd1);
    chk("t3_data", bus.ld_data, 32'd2);
    bus.ld_addr = 32'h44; #1;
    chk("t3_miss_hit", 32'(bus.ld_hit), 32'd0);
    chk("t3_miss_data", bus.ld_data, 32'd0);
    drain(2);

    // Wrap-around: ten store/ack pairs
    do_reset();
    for (int k = 0; k < 10; k++) begin
      store(32'h400 + 32'(4 * k), 32'(k * 17 + 5));
      drain(k + 1);
    end
    for (int k = 0; k < 10; k++) begin
      chk("t4_addr", dut_a.size() > k ? dut_a[k] : 32'hDEAD, 32'h400 + 32'(4 * k));
      chk("t4_data", dut_d.size() > k ? dut_d[k] : 32'hDEAD, 32'(k * 17 + 5));
    end

    // Enqueue on the same edge as an ack
    do_reset();
    store(32'h300, 32'd1);
    store(32'h304, 32'd2);
    bus.st_valid = 1'b1; bus.st_addr = 32'h308; bus.st_data = 32'd3; bus.mem_wr_ack = 1'b1;
    tick();
    bus.st_valid = 1'b0; bus.mem_wr_ack = 1'b0;
    chk("t5_count", 32'(bus.count), 32'd2);
    chk("t5_req_gap", 32'(bus.mem_wr_req), 32'd0);
    tick();
    chk("t5_req_back", 32'(bus.mem_wr_req), 32'd1);
    chk("t5_head", bus.mem_wr_addr, 32'h304);
    drain(3);
    chk("t5_last", dut_d.size() > 2 ? dut_d[2] : 32'hDEAD, 32'd3);

    // Reset while a request is outstanding, then a stray ack
    do_reset();
    for (int i = 0; i < 3; i++) store(32'h500 + 32'(4 * i), 32'(i));
    chk("t6_count", 32'(bus.count), 32'd3);
    chk("t6_req", 32'(bus.mem_wr_req), 32'd1);
    do_reset();
    bus.mem_wr_ack = 1'b1; tick(); bus.mem_wr_ack = 1'b0;
    chk("t6_req_low", 32'(bus.mem_wr_req), 32'd0);
    chk("t6_empty", 32'(bus.empty), 32'd1);
    chk("t6_no_write", 32'(dut_a.size()), 32'd0);

    // Same-word stores behind an issuing head
    do_reset();
    store(32'h80, 32'd7);
    store(32'h40, 32'd1);
    store(32'h40, 32'd2);
`ifdef STORE_BUF_COALESCE_EN
    chk("t7_count", 32'(bus.count), 32'd2);
    drain(2);
    chk("t7_second", dut_d.size() > 1 ? dut_d[1] : 32'hDEAD, 32'd2);
`else
    chk("t7_count", 32'(bus.count), 32'd3);
    drain(3);
    chk("t7_second", dut_d.size() > 1 ? dut_d[1] : 32'hDEAD, 32'd1);
    chk("t7_third", dut_d.size() > 2 ? dut_d[2] : 32'hDEAD, 32'd2);
`endif
    chk("t7_first", dut_d.size() > 0 ? dut_d[0] : 32'hDEAD, 32'd7);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus.st_valid   = ($urandom_range(0, 2) != 0);
      bus.st_addr    = 32'h600 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
      bus.st_data    = $urandom;
      bus.ld_addr    = 32'h600 + 32'(4 * $urandom_range(0, 6)) + 32'($urandom_range(0, 3));
      bus.mem_wr_ack = ($urandom_range(0, 2) == 0);
      tick();
    end
    bus.st_valid = 1'b0;
    target = m_log_a.size() + mq.size();
    drain(target);
    chk("rand_len", 32'(dut_a.size()), 32'(m_log_a.size()));
    for (int i = 0; i < dut_a.size() && i < m_log_a.size(); i++) begin
      if (dut_a[i] !== m_log_a[i] || dut_d[i] !== m_log_d[i]) begin
        chk("rand_write_addr", dut_a[i], m_log_a[i]);
        chk("rand_write_data", dut_d[i], m_log_d[i]);
      end
    end

    check_en = 1'b0;
    $display("note: %0d stores offered while full were dropped", n_drop);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
